// File: rtl/uart_pkg.sv
// Shared definitions for the UART packet sequencer: packet framing constants,
// FSM state encoding and the byte/checksum helpers used to build each packet.
package uart_pkg;

    // Framing
    localparam logic [7:0]  SYNC_BYTE_DEFAULT = 8'hA5;
    localparam int unsigned PKT_LEN           = 7;
    localparam int unsigned IDX_W             = 3;
    localparam int unsigned CH_ID_W           = 4;
    localparam int unsigned MAX_CH            = 16;

    // Index of the checksum byte, i.e. the last byte of a packet
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PKT_LEN - 1);

    // State encoding
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ARB   = 3'd1;
    localparam logic [2:0] ST_START = 3'd2;
    localparam logic [2:0] ST_HOLD  = 3'd3;
    localparam logic [2:0] ST_WAIT  = 3'd4;

    typedef enum logic [2:0] {
        IDLE  = ST_IDLE,
        ARB   = ST_ARB,
        START = ST_START,
        HOLD  = ST_HOLD,
        WAIT  = ST_WAIT
    } seq_state_t;

    // 8-bit sum of channel id byte and the four data bytes; carries are dropped.
    function automatic logic [7:0] pkt_checksum(input logic [CH_ID_W-1:0] ch_id,
                                                input logic [31:0]        word);
        logic [7:0] sum;
        sum = {4'b0000, ch_id};
        sum = sum + word[31:24];
        sum = sum + word[23:16];
        sum = sum + word[15:8];
        sum = sum + word[7:0];
        return sum;
    endfunction

    // Byte at position idx of the packet: sync, id, data MSB first, checksum.
    function automatic logic [7:0] pkt_byte(input logic [IDX_W-1:0]   idx,
                                            input logic [7:0]         sync,
                                            input logic [CH_ID_W-1:0] ch_id,
                                            input logic [31:0]        word);
        logic [7:0] b;
        case (idx)
            3'd0:    b = sync;
            3'd1:    b = {4'b0000, ch_id};
            3'd2:    b = word[31:24];
            3'd3:    b = word[23:16];
            3'd4:    b = word[15:8];
            3'd5:    b = word[7:0];
            default: b = pkt_checksum(ch_id, word);
        endcase
        return b;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requesting channel after
// "last" (wrapping modulo NUM_CH). The "last" register lives in the caller.
module rr_arbiter #(
    parameter int unsigned NUM_CH = 2
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [3:0]        last,
    output logic [3:0]        grant_idx,
    output logic              any_req
);

    // Scan offsets from farthest to nearest so the nearest requester overwrites.
    always_comb begin
        any_req   = |req;
        grant_idx = last;
        for (int off = int'(NUM_CH); off >= 1; off--) begin
            for (int k = 0; k < int'(NUM_CH); k++) begin
                if (req[k] && (k == ((int'(last) + off) % int'(NUM_CH)))) begin
                    grant_idx = 4'(k);
                end
            end
        end
    end

endmodule

// File: rtl/uart_packet_sequencer.sv
// Shares one byte-wide UART transmitter between NUM_CH 32-bit sources. A
// round-robin winner's word is latched and sent as a 7-byte packet
// (sync, id, 4 data bytes MSB first, checksum) using a start/busy handshake.
module uart_packet_sequencer
    import uart_pkg::*;
#(
    parameter int unsigned NUM_CH    = 2,
    parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
    input  logic                   Clk,
    input  logic                   rst,
    input  logic [NUM_CH-1:0]      i_req,
    input  logic [32*NUM_CH-1:0]   i_data,
    output logic [NUM_CH-1:0]      o_ack,
    output logic                   o_tx_start,
    output logic [7:0]             o_tx_byte,
    input  logic                   i_tx_busy,
    output logic                   o_busy
);

    seq_state_t           state_q, state_d;
    logic [3:0]           last_q, last_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [CH_ID_W-1:0]   ch_id_q, ch_id_d;
    logic [31:0]          word_q, word_d;
    logic [NUM_CH-1:0]    ack_q, ack_d;
    logic                 busy_q, busy_d;
    logic                 tx_start_q, tx_start_d;
    logic [7:0]           tx_byte_q, tx_byte_d;

    logic [3:0]           grant_idx;
    logic                 any_req;
    logic [31:0]          grant_word;

    rr_arbiter #(
        .NUM_CH (NUM_CH)
    ) u_arb (
        .req       (i_req),
        .last      (last_q),
        .grant_idx (grant_idx),
        .any_req   (any_req)
    );

    // Word of the channel currently chosen by the arbiter.
    always_comb begin
        grant_word = '0;
        for (int k = 0; k < int'(NUM_CH); k++) begin
            if (grant_idx == 4'(k)) begin
                grant_word = i_data[32*k +: 32];
            end
        end
    end

    // Next-state and registered-output logic of the packet FSM.
    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        idx_d      = idx_q;
        ch_id_d    = ch_id_q;
        word_d     = word_q;
        ack_d      = '0;
        busy_d     = busy_q;
        tx_start_d = 1'b0;
        tx_byte_d  = tx_byte_q;

        unique case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (any_req) begin
                    state_d = ARB;
                end
            end

            ARB: begin
                // A request that vanished before arbitration is simply dropped.
                if (any_req) begin
                    ch_id_d = grant_idx;
                    word_d  = grant_word;
                    last_d  = grant_idx;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    for (int k = 0; k < int'(NUM_CH); k++) begin
                        ack_d[k] = (grant_idx == 4'(k));
                    end
                    state_d = START;
                end else begin
                    state_d = IDLE;
                end
            end

            START: begin
                if (!i_tx_busy) begin
                    tx_start_d = 1'b1;
                    tx_byte_d  = pkt_byte(idx_q, SYNC_BYTE, ch_id_q, word_q);
                    state_d    = HOLD;
                end
            end

            // Transmitter busy is not yet valid on the cycle it sees the start.
            HOLD: begin
                state_d = WAIT;
            end

            WAIT: begin
                if (!i_tx_busy) begin
                    if (idx_q == LAST_IDX) begin
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = START;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register with synchronous reset; "last" resets so channel 0 wins first.
    always_ff @(posedge Clk) begin
        if (rst) begin
            state_q    <= IDLE;
            last_q     <= 4'(NUM_CH - 1);
            idx_q      <= '0;
            ch_id_q    <= '0;
            word_q     <= '0;
            ack_q      <= '0;
            busy_q     <= 1'b0;
            tx_start_q <= 1'b0;
            tx_byte_q  <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            idx_q      <= idx_d;
            ch_id_q    <= ch_id_d;
            word_q     <= word_d;
            ack_q      <= ack_d;
            busy_q     <= busy_d;
            tx_start_q <= tx_start_d;
            tx_byte_q  <= tx_byte_d;
        end
    end

    assign o_ack      = ack_q;
    assign o_busy     = busy_q;
    assign o_tx_start = tx_start_q;
    assign o_tx_byte  = tx_byte_q;

endmodule

// File: doc/uart_packet_sequencer.md
Name: uart_packet_sequencer

Overview:
Shares one byte-wide UART transmitter between NUM_CH 32-bit data sources, e.g. velocity, position and setpoint channels.
- Round-robin arbitration between requesting channels.
- Latches the winning word and frames it as a 7-byte packet: sync, channel id, 4 data bytes MSB first, checksum.
- Sequences the bytes into the transmitter with a start/busy handshake.
- Sits between the sampling logic that detects changed words and the UART TX serializer.

Parameters:
- NUM_CH, 2, number of requesting channels; legal range 1..16.
- SYNC_BYTE, 8'hA5, first byte of every packet.

Ports:
- Clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- i_req  input  NUM_CH  per-channel request; level, held until the matching o_ack.
- i_data  input  32*NUM_CH  packed words; channel k at [32k+31:32k]; must be stable while i_req[k] is high.
- o_ack  output  NUM_CH  one-cycle pulse; the granted channel's word has been latched.
- o_tx_start  output  1  one-cycle pulse: transmitter loads o_tx_byte.
- o_tx_byte  output  8  byte to transmit; valid while o_tx_start is high.
- i_tx_busy  input  1  transmitter busy; rises the cycle after o_tx_start and falls when the stop bit completes.
- o_busy  output  1  high from grant until the last byte completes.

Behaviour:
- Clock and reset:
  - One clock (Clk).
  - Reset is synchronous and active-high (rst). At the next edge with rst=1:
    - all outputs go to 0 and state goes to IDLE;
    - the byte index is cleared and the latched word is cleared;
    - the round-robin pointer "last" is set to NUM_CH-1, so channel 0 wins first.
  - Reset mid-packet abandons the packet with no further o_tx_start. A byte already in flight in the transmitter is not recalled.
- State machine: IDLE, ARB, START, HOLD, WAIT.
- IDLE: o_busy=0. If i_req != 0, go to ARB.
- ARB (1 cycle):
  - Select the first requesting index after "last", modulo NUM_CH.
  - Latch its word and channel id; update "last"; set byte index to 0.
  - Registered o_ack[k]=1 for exactly the next cycle.
  - o_busy=1 from this edge onward.
  - If i_req dropped to 0 before ARB, return to IDLE; no ack is issued.
- START:
  - When i_tx_busy=0: o_tx_start=1 for one cycle with o_tx_byte = byte[idx], then go to HOLD.
  - When i_tx_busy=1: stay in START with o_tx_start=0.
- HOLD (1 cycle): ignore i_tx_busy, which covers the transmitter's one-cycle rise latency. Go to WAIT.
- WAIT: when i_tx_busy=0:
  - if idx==6, go to IDLE (o_busy falls on that edge);
  - otherwise idx+=1 and go to START.
- Packet bytes: idx0=SYNC_BYTE, idx1={4'b0,ch_id}, idx2=d[31:24], idx3=d[23:16], idx4=d[15:8], idx5=d[7:0], idx6=checksum.
- Checksum: 8-bit sum of bytes idx1..idx5, modulo 256 (carries discarded).
- Requests arriving during a packet are not sampled until return to IDLE. Any number of channels may request simultaneously; strict round-robin prevents starvation.
- The requester must deassert i_req within 1 cycle of o_ack. A request still high in the next IDLE is treated as a new request.
- o_tx_byte holds its last value outside START. o_tx_start is never high two consecutive cycles.
- Minimum gap between packets: 1 IDLE cycle.

Decomposition:
- Shared package uart_pkg:
  - SYNC_BYTE default;
  - PKT_LEN=7;
  - state encoding IDLE/ARB/START/HOLD/WAIT (3-bit localparams);
  - byte-index width 3.
- One sub-module: rr_arbiter (parameter NUM_CH).
  - Inputs: req, last.
  - Outputs: grant_idx and any_req.
  - Purely combinational; the "last" register stays in the sequencer.

Test Plan:
- Channel 0 single request:
  - Stimulus: after reset, i_req=2'b01, i_data[31:0]=32'h12345678; transmitter model raises busy 1 cycle after start and holds it 10 cycles.
  - Required: o_ack=2'b01 for one cycle; 7 start pulses carrying A5,00,12,34,56,78,14; o_busy returns to 0 after the 7th busy falls.
- Checksum wrap on channel 1: i_req=2'b10, i_data[63:32]=32'hFFFFFFFF -> bytes A5,01,FF,FF,FF,FF,FD.
- Simultaneous requests:
  - Stimulus: i_req=2'b11 held continuously, re-asserted after each ack.
  - Required: grants alternate ch0, ch1, ch0, ch1; no channel granted twice in a row.
- Busy stretch: hold i_tx_busy=1 for 3 extra cycles before START -> o_tx_start stays 0 until busy=0, then exactly one pulse.
- Reset mid-packet: assert rst one cycle after the 3rd o_tx_start -> next cycle all outputs 0, no further starts; next request is ch0 first, packet restarts at A5.
- Dropped request: i_req pulses 2'b01 for one cycle with the sequencer in IDLE and drops before ARB -> no o_ack, no o_tx_start, return to IDLE.
